// File: rtl/regfile_writeback_unit_pkg.sv
// ----------------------------------------------------------------------------
// regfile_writeback_unit_pkg
//   Shared definitions for the register-file write-back path: default data and
//   register-index widths, the x0 index (shared with register_file), the
//   arbitration grant encoding and a saturating add helper for the x0 counter.
// ----------------------------------------------------------------------------
package regfile_writeback_unit_pkg;

    localparam int unsigned RV_DATA_WIDTH = 32;
    localparam int unsigned RV_ADDR_WIDTH = 5;
    localparam int unsigned RV_X0_IDX     = 0;

    // Which source (if any) retires this cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ALU  = 2'd1,
        GNT_LSU  = 2'd2
    } grant_e;

    // Add 0..2 to an 8-bit count, clamping at 255.
    function automatic logic [7:0] sat_add8(input logic [7:0] v, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, v} + {7'b0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/regfile_writeback_unit_wb_fifo.sv
// ----------------------------------------------------------------------------
// wb_fifo
//   Small synchronous FIFO buffering {rd, data} results from one producer.
//   Pointers carry an extra wrap bit so full and empty are distinguished
//   without an occupancy counter. Push and pop in the same cycle are allowed.
//   Ports:
//     clk, rst_n  clock / asynchronous active-low reset
//     i_flush     synchronous clear; same-cycle push and pop are ignored
//     i_push      write i_data (ignored when full)
//     i_data      entry to write
//     i_pop       retire the head entry (ignored when empty)
//     o_data      head entry (valid when !o_empty)
//     o_full      no free slot
//     o_empty     no entry held
// ----------------------------------------------------------------------------
module wb_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW:0]      r_wr_ptr;
    logic [PW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_push;
    logic w_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                     (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);

    assign w_push = i_push && !o_full  && !i_flush;
    assign w_pop  = i_pop  && !o_empty && !i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (PW+1)'(1);
        end
    end

    // Storage needs no reset: contents are only observed through the pointers.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[PW-1:0]] <= i_data;
    end

    assign o_data = r_mem[r_rd_ptr[PW-1:0]];

endmodule

// File: rtl/regfile_writeback_unit.sv
// ----------------------------------------------------------------------------
// regfile_writeback_unit
//   Write-side initiator for register_file. Buffers ALU and LSU results in
//   one FIFO each, retires at most one per cycle and drives a registered
//   write_enable/rd/write_data. Results targeting x0 are dropped and counted.
//   Ports:
//     clk, rst_n            clock / asynchronous active-low reset
//     flush                 kill all pending writes (and same-cycle pushes)
//     alu_valid/ready/rd/data   ALU result handshake
//     lsu_valid/ready/rd/data   LSU result handshake
//     write_enable, rd, write_data  registered write port to register_file
//     x0_drops              saturating count of discarded rd==0 results
//     idle                  both FIFOs empty and no write being driven
// ----------------------------------------------------------------------------
module regfile_writeback_unit
    import regfile_writeback_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RV_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = RV_ADDR_WIDTH,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] rd,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic [7:0]            x0_drops,
    output logic                  idle
);

    localparam int unsigned ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
    localparam int unsigned WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam logic [ADDR_WIDTH-1:0] X0 = ADDR_WIDTH'(RV_X0_IDX);

    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_rd;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [7:0]            r_x0_drops;
    logic [WAIT_W-1:0]     r_wait_cnt;

    logic               w_alu_full, w_alu_empty;
    logic               w_lsu_full, w_lsu_empty;
    logic [ENTRY_W-1:0] w_alu_head, w_lsu_head, w_sel;
    logic               w_alu_acc, w_lsu_acc;
    logic               w_alu_x0, w_lsu_x0;
    logic               w_alu_push, w_lsu_push;
    grant_e             w_grant;

    // Ready depends on registered FIFO state only.
    assign alu_ready = !w_alu_full;
    assign lsu_ready = !w_lsu_full;

    assign w_alu_acc  = alu_valid && alu_ready;
    assign w_lsu_acc  = lsu_valid && lsu_ready;
    assign w_alu_x0   = w_alu_acc && (alu_rd == X0);
    assign w_lsu_x0   = w_lsu_acc && (lsu_rd == X0);
    assign w_alu_push = w_alu_acc && !w_alu_x0;
    assign w_lsu_push = w_lsu_acc && !w_lsu_x0;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_alu_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (flush),
        .i_push  (w_alu_push),
        .i_data  ({alu_rd, alu_data}),
        .i_pop   (w_grant == GNT_ALU),
        .o_data  (w_alu_head),
        .o_full  (w_alu_full),
        .o_empty (w_alu_empty)
    );

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_lsu_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (flush),
        .i_push  (w_lsu_push),
        .i_data  ({lsu_rd, lsu_data}),
        .i_pop   (w_grant == GNT_LSU),
        .o_data  (w_lsu_head),
        .o_full  (w_lsu_full),
        .o_empty (w_lsu_empty)
    );

    // LSU has priority; the ALU wins when the LSU is empty or has waited
    // MAX_WAIT consecutive losses. Nothing retires during a flush.
    always_comb begin
        w_grant = GNT_NONE;
        if (!flush) begin
            if (!w_alu_empty && (w_lsu_empty || (r_wait_cnt == WAIT_W'(MAX_WAIT)))) begin
                w_grant = GNT_ALU;
            end else if (!w_lsu_empty) begin
                w_grant = GNT_LSU;
            end
        end
    end

    assign w_sel = (w_grant == GNT_ALU) ? w_alu_head : w_lsu_head;

    // Output register: rd/write_data hold their last value when nothing retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_rd    <= '0;
            r_wdata <= '0;
        end else if (w_grant != GNT_NONE) begin
            r_we    <= 1'b1;
            r_rd    <= w_sel[ENTRY_W-1:DATA_WIDTH];
            r_wdata <= w_sel[DATA_WIDTH-1:0];
        end else begin
            r_we    <= 1'b0;
        end
    end

    // Starvation counter: counts consecutive ALU losses; can never pass
    // MAX_WAIT because the ALU is granted once it gets there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (flush || w_alu_empty || (w_grant == GNT_ALU)) begin
            r_wait_cnt <= '0;
        end else if (w_grant == GNT_LSU) begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
        end
    end

    // Both producers may drop an x0 result in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x0_drops <= '0;
        end else if (w_alu_x0 || w_lsu_x0) begin
            r_x0_drops <= sat_add8(r_x0_drops, {1'b0, w_alu_x0} + {1'b0, w_lsu_x0});
        end
    end

    assign write_enable = r_we;
    assign rd           = r_rd;
    assign write_data   = r_wdata;
    assign x0_drops     = r_x0_drops;
    assign idle         = w_alu_empty && w_lsu_empty && !r_we;

endmodule

// File: tb/tb_regfile_writeback_unit.sv
module tb_regfile_writeback_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic [4:0]  lsu_rd = '0;
    logic [31:0] lsu_data = '0;
    logic        write_enable;
    logic [4:0]  rd;
    logic [31:0] write_data;
    logic [7:0]  x0_drops;
    logic        idle;

    regfile_writeback_unit #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5),
        .FIFO_DEPTH (2),
        .MAX_WAIT   (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .lsu_valid    (lsu_valid),
        .lsu_ready    (lsu_ready),
        .lsu_rd       (lsu_rd),
        .lsu_data     (lsu_data),
        .write_enable (write_enable),
        .rd           (rd),
        .write_data   (write_data),
        .x0_drops     (x0_drops),
        .idle         (idle)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;
    int          cyc    = 0;
    int          exp_x0 = 0;
    int unsigned wr_cnt = 0;
    int          alu_first_wr_cyc = -1;

    logic [36:0] alu_q[$];
    logic [36:0] lsu_q[$];
    logic [4:0]  wr_rd_log[$];
    logic [31:0] wr_data_log[$];
    logic [31:0] rf [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Register-file model: captures on the edge after write_enable is driven.
    always @(posedge clk) if (rst_n && write_enable) rf[rd] <= write_data;

    // Scoreboard: each driven write must be the head of one source's queue.
    always @(negedge clk) begin
        if (rst_n && write_enable) begin
            logic [36:0] ent;
            ent = {rd, write_data};
            wr_cnt++;
            wr_rd_log.push_back(rd);
            wr_data_log.push_back(write_data);
            if (write_data[31:28] == 4'hA && alu_first_wr_cyc < 0) alu_first_wr_cyc = cyc;
            n_cmp++;
            if (alu_q.size() > 0 && alu_q[0] == ent) begin
                void'(alu_q.pop_front());
            end else if (lsu_q.size() > 0 && lsu_q[0] == ent) begin
                void'(lsu_q.pop_front());
            end else begin
                n_fail++;
                $display("FAIL scoreboard: got rd=%0d data=0x%08h, expected alu head %s / lsu head %s",
                         rd, write_data,
                         (alu_q.size() > 0) ? $sformatf("0x%010h", alu_q[0]) : "none",
                         (lsu_q.size() > 0) ? $sformatf("0x%010h", lsu_q[0]) : "none");
            end
        end
    end

    // Called at a negedge; returns at the next negedge after one rising edge.
    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                         input logic fl, output logic aa, output logic la);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
        flush = fl;
        #1;
        aa = av && alu_ready;
        la = lv && lsu_ready;
        if (aa && ard == 5'd0 && exp_x0 < 255) exp_x0++;
        if (la && lrd == 5'd0 && exp_x0 < 255) exp_x0++;
        if (fl) begin
            alu_q.delete();
            lsu_q.delete();
        end else begin
            if (aa && ard != 5'd0) alu_q.push_back({ard, ad});
            if (la && lrd != 5'd0) lsu_q.push_back({lrd, ld});
        end
        @(posedge clk);
        @(negedge clk);
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        logic aa, la;
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, aa, la);
    endtask

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        int unsigned exp_wr;
        logic [4:0]  exp_first_rd;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic        aa, la;
        int unsigned wr0;
        int          idx;
        int          alu_i;
        int          acc3_cyc;
        logic        seen_full;

        vecs[0] = '{1, 5,  32'hA000_1005, 0, 0,  32'h0,          1, 5};
        vecs[1] = '{0, 0,  32'h0,          1, 6,  32'h5000_1006, 1, 6};
        vecs[2] = '{1, 7,  32'hA000_1007, 1, 8,  32'h5000_1008, 2, 8};
        vecs[3] = '{1, 0,  32'hA000_1000, 0, 0,  32'h0,          0, 0};
        vecs[4] = '{1, 9,  32'hA000_1009, 1, 0,  32'h5000_1000, 1, 9};
        vecs[5] = '{1, 0,  32'hA000_2000, 1, 0,  32'h5000_2000, 0, 0};
        vecs[6] = '{1, 30, 32'hA000_101E, 1, 31, 32'h5000_101F, 2, 31};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_we", {31'b0, write_enable}, 0);
        chk("rst_rd", {27'b0, rd}, 0);
        chk("rst_wdata", write_data, 0);
        chk("rst_x0", {24'b0, x0_drops}, 0);
        chk("rst_idle", {31'b0, idle}, 1);
        chk("rst_alu_ready", {31'b0, alu_ready}, 1);
        chk("rst_lsu_ready", {31'b0, lsu_ready}, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single ALU write: write_enable one cycle, one edge after accept
        drive(1, 1, 32'hDEADBEEF, 0, 0, 0, 0, aa, la);
        chk("single_we_n1", {31'b0, write_enable}, 0);
        idle_cycles(1);
        chk("single_we", {31'b0, write_enable}, 1);
        chk("single_rd", {27'b0, rd}, 1);
        chk("single_data", write_data, 32'hDEADBEEF);
        idle_cycles(1);
        chk("single_we_off", {31'b0, write_enable}, 0);
        chk("single_rf1", rf[1], 32'hDEADBEEF);

        // Single x0 push
        wr0 = wr_cnt;
        drive(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, aa, la);
        idle_cycles(3);
        chk("x0_no_write", wr_cnt - wr0, 0);
        chk("x0_drops_1", {24'b0, x0_drops}, 1);

        // Table-driven single-cycle patterns
        for (int v = 0; v < 7; v++) begin
            wr0 = wr_cnt;
            wr_rd_log.delete();
            drive(vecs[v].av, vecs[v].ard, vecs[v].ad, vecs[v].lv, vecs[v].lrd, vecs[v].ld, 0, aa, la);
            idle_cycles(4);
            chk($sformatf("vec%0d_writes", v), wr_cnt - wr0, vecs[v].exp_wr);
            if (vecs[v].exp_wr > 0 && wr_rd_log.size() > 0)
                chk($sformatf("vec%0d_first_rd", v), {27'b0, wr_rd_log[0]}, {27'b0, vecs[v].exp_first_rd});
            chk($sformatf("vec%0d_x0", v), {24'b0, x0_drops}, exp_x0);
            chk($sformatf("vec%0d_idle", v), {31'b0, idle}, 1);
        end

        // Contention: ALU rd=3 waits exactly MAX_WAIT LSU writes
        wr_data_log.delete();
        drive(1, 3, 32'hA000_0003, 1, 2, 32'h5000_0002, 0, aa, la);
        idx = 3;
        for (int k = 0; k < 40 && idx <= 9; k++) begin
            drive(0, 0, 0, 1, 5'(idx), 32'h5000_0000 + idx, 0, aa, la);
            if (la) idx++;
        end
        idle_cycles(6);
        chk("cont_all_lsu_pushed", idx, 10);
        idx = -1;
        foreach (wr_data_log[i]) if (wr_data_log[i] == 32'hA000_0003 && idx < 0) idx = i;
        chk("cont_alu_position", idx, 4);
        chk("cont_total_writes", wr_data_log.size(), 9);
        chk("cont_queues_empty", alu_q.size() + lsu_q.size(), 0);

        // Backpressure: 3 ALU pushes against a saturating LSU
        alu_first_wr_cyc = -1;
        alu_i = 0;
        acc3_cyc = -1;
        seen_full = 1'b0;
        for (int k = 0; k < 40 && alu_i < 3; k++) begin
            if (k == 2) chk("bp_alu_ready_full", {31'b0, alu_ready}, 0);
            if (!alu_ready) seen_full = 1'b1;
            drive(1, 5'(20 + alu_i), 32'hA000_0100 + alu_i,
                  1, 5'(1 + (k % 8)), 32'h5000_0100 + k, 0, aa, la);
            if (aa) begin
                if (alu_i == 2) acc3_cyc = cyc - 1;
                alu_i++;
            end
        end
        chk("bp_alu_accepted", alu_i, 3);
        chk("bp_seen_full", {31'b0, seen_full}, 1);
        chk("bp_third_after_pop", acc3_cyc, alu_first_wr_cyc);
        idle_cycles(8);
        chk("bp_queues_empty", alu_q.size() + lsu_q.size(), 0);

        // Flush with both FIFOs holding entries and a coinciding push
        for (int k = 0; k < 3; k++)
            drive(1, 5'(14 + k), 32'hA000_0200 + k, 1, 5'(17 + k), 32'h5000_0200 + k, 0, aa, la);
        chk("fl_busy", {31'b0, idle}, 0);
        drive(1, 12, 32'hBAD0_0012, 1, 13, 32'hBAD0_0013, 1, aa, la);
        wr0 = wr_cnt;
        chk("fl_we", {31'b0, write_enable}, 0);
        chk("fl_idle", {31'b0, idle}, 1);
        chk("fl_alu_ready", {31'b0, alu_ready}, 1);
        idle_cycles(5);
        chk("fl_no_writes", wr_cnt - wr0, 0);
        chk("fl_x0_kept", {24'b0, x0_drops}, exp_x0);

        // Asynchronous reset while a write is being driven
        drive(1, 10, 32'hA000_0010, 1, 11, 32'h5000_0011, 0, aa, la);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_we", {31'b0, write_enable}, 0);
        chk("arst_rd", {27'b0, rd}, 0);
        chk("arst_wdata", write_data, 0);
        chk("arst_idle", {31'b0, idle}, 1);
        chk("arst_ready", {30'b0, alu_ready, lsu_ready}, 3);
        chk("arst_x0", {24'b0, x0_drops}, 0);
        alu_q.delete();
        lsu_q.delete();
        exp_x0 = 0;
        @(negedge clk);
        rst_n = 1'b1;
        wr0 = wr_cnt;
        idle_cycles(4);
        chk("arst_no_writes", wr_cnt - wr0, 0);

        // x0 saturation
        wr0 = wr_cnt;
        for (int k = 0; k < 300; k++) drive(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, aa, la);
        idle_cycles(2);
        chk("x0_sat_model", {24'b0, x0_drops}, exp_x0);
        chk("x0_sat_255", {24'b0, x0_drops}, 255);
        chk("x0_sat_no_write", wr_cnt - wr0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
